if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sources the instruction/PC pair and the write/flush controls consumed by the IF/ID pipeline register.
- Owns the fetch PC, issues requests to a variable-latency instruction memory, and buffers returned words in a 2-entry queue so that hazard stalls never lose a fetched instruction.
- Applies branch/jump redirects from later stages by discarding stale fetches and inserting a bubble.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; only 2 is supported.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset; state clears immediately when reset is low.
- stall, input, 1, hazard unit holds IF/ID; head entry is not consumed.
- redirect, input, 1, branch/jump taken this cycle.
- redirect_pc, input, 32, new fetch target; sampled when redirect=1.
- imem_req, output, 1, instruction memory request valid.
- imem_addr, output, 32, request address (fetch PC).
- imem_gnt, input, 1, request accepted when imem_req=1 and imem_gnt=1 in the same cycle.
- imem_rvalid, input, 1, read data valid, arriving at least 1 cycle after grant.
- imem_rdata, input, 32, instruction word.
- instruction, output, 32, instruction for IF/ID; 0 when if_id_flush=1.
- pc, output, 32, PC of `instruction`; IF/ID adds 4 to it.
- if_id_write, output, 1, IF/ID write enable, 1=write.
- if_id_flush, output, 1, IF/ID flush, 1=load a NOP bubble.

Behaviour:
- State:
  - fetch_pc, 32 bits.
  - Buffer of {pc, instr} pairs with count 0..2, read pointer and write pointer (1 bit each, wrap-around).
  - outstanding flag and discard flag.
- Reset (reset low, async):
  - fetch_pc=RESET_PC, count=0, pointers=0, outstanding=0, discard=0.
  - Outputs: imem_req=0, instruction=0, pc=0, if_id_write=0, if_id_flush=0.
- Request issue (combinational):
  - imem_req = !outstanding && (count<2) && !redirect.
  - imem_addr = fetch_pc; address is stable while imem_req is held.
  - On grant: outstanding<=1 and fetch_pc<=fetch_pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
  - Only one request may be outstanding at a time.
- Response handling (imem_rvalid=1):
  - outstanding<=0.
  - If discard=1 or redirect=1: drop the word and clear discard.
  - Otherwise push {fetch_pc-4, imem_rdata} into the buffer.
  - No push ever occurs when full; the issue rule guarantees space.
  - Push and pop in the same cycle are legal; count is unchanged.
- Output selection, in priority order:
  1. redirect=1: if_id_flush=1, if_id_write=0, no pop.
  2. stall=1: if_id_write=0, if_id_flush=0, outputs show the head entry (or 0 when empty), no pop.
  3. count>0: instruction/pc = head entry, if_id_write=1, if_id_flush=0, pop.
  4. count=0: if_id_flush=1, if_id_write=0, instruction=0, pc=fetch_pc (bubble).
- Redirect cycle:
  - Buffer cleared (count=0).
  - fetch_pc<=redirect_pc.
  - If outstanding=1 and no rvalid this cycle: discard<=1.
  - imem_req=0 this cycle; the first request to redirect_pc is issued the next cycle if not outstanding.
- Redirect and stall together: redirect wins (flush).
- Latency: an instruction granted at cycle T with rvalid at T+k appears on the outputs at T+k+1 when the buffer was empty and no stall is active.
- Mid-operation reset: in-flight response is abandoned; any rvalid arriving after reset release while outstanding=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output ports bubble_cnt[31:0] and redirect_cnt[31:0], both reset to 0.
  - bubble_cnt increments on every output-selection case 4 cycle.
  - redirect_cnt increments on every redirect cycle.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with a memory that grants immediately and returns rvalid 1 cycle later -> first imem_addr=0x3000; outputs pc sequence 0x3000, 0x3004, 0x3008 with if_id_write=1; first cycle after reset shows if_id_flush=1.
- stall held 3 cycles while 2 entries are buffered -> instruction/pc frozen at the head, if_id_write=0, imem_req=0 once count=2; after release the 2 entries drain in order with no gap.
- redirect to 0x0040_0100 while a request to 0x3008 is outstanding, rvalid 2 cycles later -> if_id_flush=1 in the redirect cycle, 0x3008 word dropped, next imem_addr=0x0040_0100, next valid pc=0x0040_0100.
- Memory latency 4 cycles, no stall -> if_id_flush=1 on every cycle the buffer is empty; pc increments by 4 only on valid outputs.
- redirect, stall and rvalid all asserted in the same cycle -> flush=1, returned word dropped, count=0.
- reset asserted low mid-WAIT, then a stray rvalid after release -> word ignored, fetch restarts at 0x3000; with FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage with a 2-entry fetch buffer and redirect handling.
// Define FETCH_PERF_EN to add bubble/redirect performance counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        if_id_write,
    output logic        if_id_flush
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    localparam logic [1:0] FULL = BUF_DEPTH[1:0];

    logic [31:0] fetch_pc;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic        outstanding;
    logic        discard;

    logic        grant;
    logic        rsp;
    logic        push;
    logic        pop;

    assign imem_req  = reset && !outstanding && (count < FULL) && !redirect;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    // Responses only count while a request is in flight; strays are ignored.
    assign rsp       = imem_rvalid && outstanding;
    assign push      = rsp && !discard && !redirect;

    always_comb begin
        instruction = '0;
        pc          = '0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        pop         = 1'b0;
        if (!reset) begin
            pop = 1'b0;
        end else if (redirect) begin
            if_id_flush = 1'b1;
        end else if (stall) begin
            if (count != 2'd0) begin
                instruction = fifo_instr[rd_ptr];
                pc          = fifo_pc[rd_ptr];
            end
        end else if (count != 2'd0) begin
            instruction = fifo_instr[rd_ptr];
            pc          = fifo_pc[rd_ptr];
            if_id_write = 1'b1;
            pop         = 1'b1;
        end else begin
            if_id_flush = 1'b1;
            pc          = fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (rsp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (redirect) begin
                count    <= '0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                fetch_pc <= redirect_pc;
                // The in-flight word belongs to the old path.
                if (outstanding && !rsp)
                    discard <= 1'b1;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]    <= fetch_pc - 32'd4;
                    fifo_instr[wr_ptr] <= imem_rdata;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble;

    assign bubble = reset && !redirect && !stall && (count == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            if (bubble && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
            if (redirect && redirect_cnt != 32'hFFFF_FFFF)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of if_fetch_unit against a
// variable-latency memory model (word = addr ^ 0x5A00_0000).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        if_id_write;
    logic        if_id_flush;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] redirect_cnt;
`endif

    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;
    int          checks = 0;
    int          errors = 0;

    assign imem_gnt = gnt_en;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instruction(instruction),
        .pc(pc), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush)
`ifdef FETCH_PERF_EN
        , .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    // Called at a negedge: note any grant, cross the edge, drive memory.
    task automatic adv();
        logic        g;
        logic [31:0] ga;
        g  = imem_req && imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (g) begin
            pend  = 1'b1;
            pcnt  = lat;
            paddr = ga;
        end
        if (pend) begin
            pcnt = pcnt - 1;
            if (pcnt == 0) begin
                pend        = 1'b0;
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ 32'h5A00_0000;
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        gnt_en      = 1'b1;
        imem_rvalid = 1'b0;
        pend        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req: got %b want 0", imem_req);
        end
        if (if_id_flush !== 1'b0) begin
            errors++; $display("FAIL rst_flush: got %b want 0", if_id_flush);
        end
        if (if_id_write !== 1'b0) begin
            errors++; $display("FAIL rst_write: got %b want 0", if_id_write);
        end
        if (instruction !== 32'h0) begin
            errors++; $display("FAIL rst_instr: got %h want 0", instruction);
        end
        if (pc !== 32'h0) begin
            errors++; $display("FAIL rst_pc: got %h want 0", pc);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc [3];
        int          got;
        exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
        lat = 1;
        do_reset();
        @(negedge clk);
        checks += 3;
        if (imem_addr !== 32'h3000 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL first_req: got %b/%h want 1/00003000",
                     imem_req, imem_addr);
        end
        if (if_id_flush !== 1'b1) begin
            errors++; $display("FAIL first_flush: got %b want 1", if_id_flush);
        end
        if (if_id_write !== 1'b0) begin
            errors++; $display("FAIL first_write: got %b want 0", if_id_write);
        end
        got = 0;
        for (int i = 0; i < 12 && got < 3; i++) begin
            adv();
            @(negedge clk);
            if (if_id_write) begin
                checks++;
                if (pc !== exp_pc[got] ||
                    instruction !== (exp_pc[got] ^ 32'h5A00_0000)) begin
                    errors++;
                    $display("FAIL seq_pc%0d: got %h/%h want %h", got,
                             pc, instruction, exp_pc[got]);
                end
                got++;
            end
        end
        checks++;
        if (got != 3) begin
            errors++; $display("FAIL seq_timeout: got %0d words want 3", got);
        end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (pc !== 32'h3000 || instruction !== 32'h5A00_3000) begin
                errors++;
                $display("FAIL stall_head%0d: got %h/%h want 00003000/5a003000",
                         i, pc, instruction);
            end
            if (if_id_write !== 1'b0 || if_id_flush !== 1'b0) begin
                errors++;
                $display("FAIL stall_ctl%0d: got w%b f%b want w0 f0",
                         i, if_id_write, if_id_flush);
            end
            if (imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_req%0d: got %b want 0", i, imem_req);
            end
            adv();
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (if_id_write !== 1'b1 || pc !== 32'h3000) begin
            errors++;
            $display("FAIL drain0: got w%b pc %h want w1 00003000",
                     if_id_write, pc);
        end
        adv();
        @(negedge clk);
        checks++;
        if (if_id_write !== 1'b1 || pc !== 32'h3004 ||
            instruction !== 32'h5A00_3004) begin
            errors++;
            $display("FAIL drain1: got w%b pc %h want w1 00003004",
                     if_id_write, pc);
        end
    endtask

    task automatic test_redirect();
        logic seen_req;
        logic got;
        lat = 3;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            adv();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0100;
        @(negedge clk);
        checks += 2;
        if (if_id_flush !== 1'b1 || if_id_write !== 1'b0 ||
            instruction !== 32'h0) begin
            errors++;
            $display("FAIL redir_flush: got f%b w%b i%h want f1 w0 i0",
                     if_id_flush, if_id_write, instruction);
        end
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_req: got %b want 0", imem_req);
        end
        adv();
        redirect = 1'b0;
        seen_req = 1'b0;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!seen_req && imem_req) begin
                seen_req = 1'b1;
                checks++;
                if (imem_addr !== 32'h0040_0100) begin
                    errors++;
                    $display("FAIL redir_addr: got %h want 00400100", imem_addr);
                end
            end
            if (if_id_write) begin
                got = 1'b1;
                checks++;
                if (pc !== 32'h0040_0100 || instruction !== 32'h5A40_0100) begin
                    errors++;
                    $display("FAIL redir_first: got %h/%h want 00400100/5a400100",
                             pc, instruction);
                end
            end else begin
                adv();
            end
        end
        checks++;
        if (!got || !seen_req) begin
            errors++;
            $display("FAIL redir_timeout: got req%b word%b want 1/1",
                     seen_req, got);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (redirect_cnt !== 32'd1) begin
            errors++; $display("FAIL redir_cnt: got %0d want 1", redirect_cnt);
        end
`endif
    endtask

    task automatic test_latency();
        logic [10:0] exp_w;
        exp_w = 11'b100_0010_0000;
        lat = 4;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks += 2;
            if (if_id_write !== exp_w[i]) begin
                errors++;
                $display("FAIL lat_write%0d: got %b want %b",
                         i, if_id_write, exp_w[i]);
            end
            if (if_id_flush !== !exp_w[i]) begin
                errors++;
                $display("FAIL lat_flush%0d: got %b want %b",
                         i, if_id_flush, !exp_w[i]);
            end
            if (i == 5 || i == 10) begin
                checks++;
                if (pc !== (i == 5 ? 32'h3000 : 32'h3004)) begin
                    errors++; $display("FAIL lat_pc%0d: got %h", i, pc);
                end
            end
            adv();
        end
    endtask

    task automatic test_collision();
        lat = 1;
        do_reset();
        @(negedge clk);
        adv();
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_5000;
        @(negedge clk);
        checks += 2;
        if (imem_rvalid !== 1'b1) begin
            errors++; $display("FAIL col_setup: rvalid %b want 1", imem_rvalid);
        end
        if (if_id_flush !== 1'b1 || if_id_write !== 1'b0 ||
            instruction !== 32'h0) begin
            errors++;
            $display("FAIL col_flush: got f%b w%b i%h want f1 w0 i0",
                     if_id_flush, if_id_write, instruction);
        end
        adv();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        checks += 2;
        if (if_id_flush !== 1'b1 || if_id_write !== 1'b0 || pc !== 32'h5000) begin
            errors++;
            $display("FAIL col_empty: got f%b w%b pc %h want f1 w0 00005000",
                     if_id_flush, if_id_write, pc);
        end
        if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin
            errors++;
            $display("FAIL col_req: got %b/%h want 1/00005000", imem_req, imem_addr);
        end
        adv();
        @(negedge clk);
        adv();
        @(negedge clk);
        checks++;
        if (if_id_write !== 1'b1 || pc !== 32'h5000 ||
            instruction !== 32'h5A00_5000) begin
            errors++;
            $display("FAIL col_next: got w%b %h/%h want w1 00005000/5a005000",
                     if_id_write, pc, instruction);
        end
    endtask

    task automatic test_redirect_full();
        lat = 1;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            adv();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_6000;
        @(negedge clk);
        adv();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        checks += 2;
        if (if_id_flush !== 1'b1 || if_id_write !== 1'b0 || pc !== 32'h6000) begin
            errors++;
            $display("FAIL full_clear: got f%b w%b pc %h want f1 w0 00006000",
                     if_id_flush, if_id_write, pc);
        end
        if (imem_req !== 1'b1 || imem_addr !== 32'h6000) begin
            errors++;
            $display("FAIL full_req: got %b/%h want 1/00006000", imem_req, imem_addr);
        end
    endtask

    task automatic test_midreset();
        logic got;
        lat = 4;
        do_reset();
        @(negedge clk);
        adv();
        @(negedge clk);
        adv();
        reset = 1'b0;
        #2;
        checks += 2;
        if (imem_req !== 1'b0 || if_id_flush !== 1'b0 || if_id_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got r%b f%b w%b want 0 0 0",
                     imem_req, if_id_flush, if_id_write);
        end
`ifdef FETCH_PERF_EN
        if (bubble_cnt !== 32'd0 || redirect_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_perf: got %0d/%0d want 0/0", bubble_cnt, redirect_cnt);
        end
`else
        if (pc !== 32'h0) begin
            errors++; $display("FAIL mid_pc: got %h want 0", pc);
        end
`endif
        gnt_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL mid_restart: got %b/%h want 1/00003000",
                     imem_req, imem_addr);
        end
        adv();
        @(negedge clk);
        adv();
        @(negedge clk);
        checks++;
        if (imem_rvalid !== 1'b1) begin
            errors++; $display("FAIL mid_stray: rvalid %b want 1", imem_rvalid);
        end
        adv();
        @(negedge clk);
        checks++;
        if (if_id_write !== 1'b0 || if_id_flush !== 1'b1 ||
            imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL mid_ignore: got w%b f%b r%b a%h want w0 f1 r1 00003000",
                     if_id_write, if_id_flush, imem_req, imem_addr);
        end
        adv();
        gnt_en = 1'b1;
        got    = 1'b0;
        for (int i = 0; i < 15 && !got; i++) begin
            @(negedge clk);
            if (if_id_write) begin
                got = 1'b1;
                checks++;
                if (pc !== 32'h3000 || instruction !== 32'h5A00_3000) begin
                    errors++;
                    $display("FAIL mid_first: got %h/%h want 00003000/5a003000",
                             pc, instruction);
                end
            end else begin
                adv();
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL mid_timeout: no word after restart");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_latency();
        test_collision();
        test_redirect_full();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
